// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// It replaces the fixed-width stage registers between any two pipeline stages.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_data           upstream payload
//   out_valid/out_ready downstream handshake
//   out_data          held payload, or NOP_VALUE whenever out_valid is low
//   flush             synchronous squash of every held entry
//   cnt_clr           synchronous clear of both performance counters
//   occupancy         number of held entries (0..2)
//   stall_count       saturating count of cycles with out_valid & !out_ready
//   bubble_count      saturating count of cycles with out_ready & !out_valid
module pipe_stage_reg #(
  parameter int unsigned          WIDTH     = 166,
  parameter logic [WIDTH-1:0]     NOP_VALUE = '0,
  parameter int unsigned          COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  input  logic               flush,
  input  logic               cnt_clr,
  output logic [1:0]         occupancy,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] bubble_count
);

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;     // main entry, drives out_data
  logic [WIDTH-1:0]   s_q, s_d;     // skid entry, the younger of two
  logic               in_ready_q, in_ready_d;
  logic [COUNT_W-1:0] stall_q, stall_d;
  logic [COUNT_W-1:0] bubble_q, bubble_d;

  logic accept;
  logic drain;
  logic stall_ev;
  logic bubble_ev;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;
  assign stall_ev  = out_valid & ~out_ready;
  assign bubble_ev = out_ready & ~out_valid;

  assign out_data     = out_valid ? m_q : NOP_VALUE;
  assign occupancy    = state_q;
  assign stall_count  = stall_q;
  assign bubble_count = bubble_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StHalf;
          m_d     = in_data;
        end
      end
      StHalf: begin
        if (accept && drain) begin
          m_d = in_data;
        end else if (accept) begin
          state_d = StFull;
          s_d     = in_data;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a drain can move the state.
        if (drain) begin
          state_d = StHalf;
          m_d     = s_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // A same-cycle drain has already been seen downstream; only held entries are dropped.
    if (flush) begin
      state_d = StEmpty;
    end
    // Derived from next state only, so out_ready never reaches in_ready combinationally.
    in_ready_d = (state_d != StFull);
  end

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (cnt_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (stall_ev && (stall_q != {COUNT_W{1'b1}})) begin
        stall_d = stall_q + COUNT_W'(1);
      end
      if (bubble_ev && (bubble_q != {COUNT_W{1'b1}})) begin
        bubble_d = bubble_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StEmpty;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed-width stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipeline processor.
- One generic module replaces each fixed-width register and provides:
  - a valid/ready handshake;
  - a 2-entry skid buffer;
  - synchronous flush for branch/jump squash;
  - NOP (bubble) injection;
  - saturating stall and bubble performance counters.
- Sits between any two pipeline stages. The hazard unit drives flush and observes the counters.

Parameters:
- WIDTH, 166, payload bits carried between stages.
- NOP_VALUE, all-zeros (WIDTH bits), payload presented on out_data whenever out_valid is low.
- COUNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage presents a valid payload.
- in_ready  out  1  register can accept; registered output.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream stage consumes this cycle.
- out_data  out  WIDTH  payload to downstream stage.
- flush  in  1  synchronous squash of all held entries.
- cnt_clr  in  1  synchronous clear of both counters.
- occupancy  out  2  number of held entries, 0..2.
- stall_count  out  COUNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_count  out  COUNT_W  cycles with out_ready=1 and out_valid=0.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - state EMPTY, in_ready=1, out_valid=0, out_data=NOP_VALUE;
  - occupancy=0, both counters=0;
  - any held payload is discarded.
- Storage:
  - main register M drives out_data;
  - skid register S holds the second entry.
- Handshake terms:
  - accept = in_valid & in_ready;
  - drain = out_valid & out_ready.
- Latency: payload accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when the register was EMPTY or drained in cycle N.
- Ordering is strictly FIFO.
- States, where occupancy equals the state encoding and out_valid = (state != EMPTY):
  - EMPTY (0):
    - accept -> HALF, M<=in_data;
    - otherwise stay.
  - HALF (1):
    - accept & drain -> HALF, M<=in_data;
    - accept & !drain -> FULL, S<=in_data;
    - !accept & drain -> EMPTY;
    - neither -> stay.
  - FULL (2):
    - drain -> HALF, M<=S;
    - otherwise stay;
    - no accept is possible because in_ready=0.
- in_ready is registered:
  - next-state value is 1 unless next state is FULL;
  - there is no combinational path from out_ready to in_ready.
- out_data = M when out_valid=1, otherwise NOP_VALUE. The mux is combinational on state only.
- Flush:
  - highest priority;
  - next state EMPTY and in_ready=1 next cycle;
  - any same-cycle accept is discarded;
  - a same-cycle drain still completes, because downstream saw out_valid=1 in that cycle;
  - out_valid=0 and out_data=NOP_VALUE from the next cycle.
- Counters:
  - stall_count increments on out_valid & !out_ready;
  - bubble_count increments on out_ready & !out_valid;
  - both saturate at 2^COUNT_W-1 and never wrap;
  - cnt_clr has priority over increment (result 0);
  - flush does not clear the counters;
  - counters keep counting during flush cycles using current-cycle out_valid.
- Simultaneous flush & cnt_clr: both take effect.
- in_valid while in_ready=0: ignored, with no data corruption; upstream must hold its payload.
- Reset asserted mid-transfer: the entry is lost, and the bench shall not expect it downstream.

Test Plan:
- WIDTH=32, NOP_VALUE=0. After reset release, drive in_data=0x11111111 with in_valid=1 for 1 cycle and out_ready=1 -> next cycle out_valid=1, out_data=0x11111111, occupancy=1; following cycle out_valid=0, out_data=0.
- Stream 0xA0..0xA7 back-to-back with out_ready=1 -> one output per cycle in order, in_ready stays 1, stall_count=0.
- out_ready=0, push 0xB0, 0xB1 -> occupancy=2 and in_ready=0 the next cycle; 0xB2 is held upstream. Then raise out_ready -> outputs 0xB0, 0xB1, 0xB2 in order and stall_count equals the number of blocked cycles.
- FULL with 0xC0/0xC1; assert flush together with in_valid=1 carrying 0xC2 and out_ready=0 -> next cycle occupancy=0, out_data=0, in_ready=1; 0xC2 never appears.
- COUNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_count=15 and holds there; cnt_clr for 1 cycle -> stall_count=0.
- reset=0 asynchronously mid-cycle while FULL -> out_valid=0, in_ready=1, and counters=0 immediately, without waiting for a clock edge.
